// File: rtl/efx_clk_pkg.sv
// Shared types and constants for the refclk frequency checker.
package efx_clk_pkg;

  localparam int CLK_CNT_W = 29;
  localparam int RUN_W     = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CHECK  = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;
  localparam logic [1:0] ST_FAULT  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_CHECK  = ST_CHECK,
    S_LOCKED = ST_LOCKED,
    S_FAULT  = ST_FAULT
  } state_e;

  typedef logic [CLK_CNT_W-1:0] freq_t;
  typedef logic [RUN_W-1:0]     run_t;

  // One extra bit so larger-minus-smaller never wraps.
  function automatic logic in_tol(freq_t m, freq_t e, freq_t t);
    logic [CLK_CNT_W:0] d;
    if (m >= e) d = {1'b0, m} - {1'b0, e};
    else        d = {1'b0, e} - {1'b0, m};
    return d <= {1'b0, t};
  endfunction

  function automatic run_t run_inc(run_t r);
    return (r == '1) ? r : r + 1'b1;
  endfunction

endpackage

// File: rtl/efx_clk_window_timer.sv
// Free-running measurement window counter with a terminal strobe.
module efx_clk_window_timer
  import efx_clk_pkg::*;
#(
  parameter int WINDOW_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  output logic term_o
);

  localparam int LOG_W = $clog2(WINDOW_CYCLES);
  localparam int CNT_W = (LOG_W > 27) ? LOG_W : 27;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign term_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en_i || term_o) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/efx_clk_checker.sv
// Windowed frequency checker with lock/fault hysteresis and sticky fault.
// Optional min/max tracking: define CLK_CHECK_MINMAX_EN.
module efx_clk_checker
  import efx_clk_pkg::*;
#(
  parameter int WINDOW_CYCLES = 100000000,
  parameter int LOCK_COUNT    = 3,
  parameter int FAIL_COUNT    = 2
) (
  input  logic        refclk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [28:0] meas_freq,
  input  logic [28:0] exp_freq,
  input  logic [28:0] tol_freq,
  input  logic        clr_sticky,
  output logic        sample_stb,
  output logic [28:0] last_freq,
  output logic        in_range,
  output logic        freq_ok,
  output logic        fault,
  output logic        sticky_fault,
`ifdef CLK_CHECK_MINMAX_EN
  output logic [28:0] min_freq,
  output logic [28:0] max_freq,
`endif
  output logic [1:0]  state
);

  localparam run_t LOCK_N = run_t'(LOCK_COUNT);
  localparam run_t FAIL_N = run_t'(FAIL_COUNT);

  logic   samp, hit, enter_fault;
  state_e state_q, state_d;
  run_t   ok_q, ok_d, bad_q, bad_d;
  logic   stb_q, inr_q, ok_out_q, flt_q, stk_q, stk_d;
  freq_t  last_q;

  efx_clk_window_timer #(
    .WINDOW_CYCLES(WINDOW_CYCLES)
  ) u_timer (
    .clk   (refclk),
    .rst_n (rst_n),
    .en_i  (enable),
    .term_o(samp)
  );

  assign hit = in_tol(meas_freq, exp_freq, tol_freq);

  always_comb begin
    state_d = state_q;
    ok_d    = ok_q;
    bad_d   = bad_q;
    if (!enable) begin
      state_d = S_IDLE;
      ok_d    = '0;
      bad_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_CHECK;
          ok_d    = '0;
          bad_d   = '0;
        end
        S_CHECK: if (samp) begin
          if (hit) begin
            ok_d  = run_inc(ok_q);
            bad_d = '0;
            if (ok_d >= LOCK_N) state_d = S_LOCKED;
          end else begin
            bad_d = run_inc(bad_q);
            ok_d  = '0;
            if (bad_d >= FAIL_N) state_d = S_FAULT;
          end
        end
        S_LOCKED: if (samp) begin
          if (hit) bad_d = '0;
          else begin
            bad_d = run_inc(bad_q);
            if (bad_d >= FAIL_N) state_d = S_FAULT;
          end
        end
        S_FAULT: if (samp) begin
          if (hit) begin
            ok_d = run_inc(ok_q);
            if (ok_d >= LOCK_N) state_d = S_LOCKED;
          end else ok_d = '0;
        end
      endcase
      // Each new state starts its hysteresis from zero.
      if (state_d != state_q) begin
        ok_d  = '0;
        bad_d = '0;
      end
    end
  end

  assign enter_fault = (state_d == S_FAULT) && (state_q != S_FAULT);
  assign stk_d       = enter_fault | (stk_q & ~clr_sticky);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ok_q     <= '0;
      bad_q    <= '0;
      stb_q    <= 1'b0;
      last_q   <= '0;
      inr_q    <= 1'b0;
      ok_out_q <= 1'b0;
      flt_q    <= 1'b0;
      stk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ok_q     <= ok_d;
      bad_q    <= bad_d;
      stb_q    <= samp;
      ok_out_q <= (state_d == S_LOCKED);
      flt_q    <= (state_d == S_FAULT);
      stk_q    <= stk_d;
      if (samp) begin
        last_q <= meas_freq;
        inr_q  <= hit;
      end
    end
  end

`ifdef CLK_CHECK_MINMAX_EN
  logic  reload_q;
  freq_t min_q, max_q;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      reload_q <= 1'b1;
      min_q    <= '1;
      max_q    <= '0;
    end else begin
      if (samp && state_q != S_IDLE) begin
        if (reload_q) begin
          min_q <= meas_freq;
          max_q <= meas_freq;
        end else begin
          if (meas_freq < min_q) min_q <= meas_freq;
          if (meas_freq > max_q) max_q <= meas_freq;
        end
      end
      if (state_q == S_IDLE || clr_sticky) reload_q <= 1'b1;
      else if (samp)                       reload_q <= 1'b0;
    end
  end

  assign min_freq = min_q;
  assign max_freq = max_q;
`endif

  assign sample_stb   = stb_q;
  assign last_freq    = last_q;
  assign in_range     = inr_q;
  assign freq_ok      = ok_out_q;
  assign fault        = flt_q;
  assign sticky_fault = stk_q;
  assign state        = state_q;

endmodule

// File: tb/tb_efx_clk_checker.sv
// Scoreboard bench for efx_clk_checker with a window-level reference model.
module tb_efx_clk_checker;

  localparam int WIN  = 16;
  localparam int LOCK = 3;
  localparam int FAIL = 2;

  logic        refclk = 1'b0;
  logic        rst_n, enable, clr_sticky;
  logic [28:0] meas_freq, exp_freq, tol_freq;
  logic        sample_stb, in_range, freq_ok, fault, sticky_fault;
  logic [28:0] last_freq;
  logic [1:0]  state;

  efx_clk_checker #(
    .WINDOW_CYCLES(WIN),
    .LOCK_COUNT   (LOCK),
    .FAIL_COUNT   (FAIL)
  ) dut (
    .refclk      (refclk),
    .rst_n       (rst_n),
    .enable      (enable),
    .meas_freq   (meas_freq),
    .exp_freq    (exp_freq),
    .tol_freq    (tol_freq),
    .clr_sticky  (clr_sticky),
    .sample_stb  (sample_stb),
    .last_freq   (last_freq),
    .in_range    (in_range),
    .freq_ok     (freq_ok),
    .fault       (fault),
    .sticky_fault(sticky_fault),
    .state       (state)
  );

  always #5 refclk = ~refclk;

  typedef struct packed {
    logic [28:0] last;
    logic        inr;
    logic [1:0]  st;
    logic        ok;
    logic        flt;
    logic        stk;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;
  int tests = 0;
  int fails = 0;

  // Reference model: state as spec encoding, hysteresis as plain integers.
  int          m_st, m_ok, m_bad;
  logic        m_stk, m_inr;
  logic [28:0] m_last;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic logic near(input logic [28:0] m, input logic [28:0] e,
                                input logic [28:0] t);
    longint d;
    d = (longint'(m) > longint'(e)) ? longint'(m) - longint'(e)
                                    : longint'(e) - longint'(m);
    return d <= longint'(t);
  endfunction

  function automatic int sat(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  task automatic model_reset(input logic full);
    m_st = 0; m_ok = 0; m_bad = 0;
    if (full) begin
      m_stk = 0; m_inr = 0; m_last = '0;
    end
  endtask

  // One full measurement window ending on its sample edge.
  task automatic window(input logic [28:0] m, input logic [28:0] e,
                        input logic [28:0] t, input logic clr);
    exp_t x;
    logic hit;
    int   nxt;
    enable = 1'b1; meas_freq = m; exp_freq = e; tol_freq = t;
    if (m_st == 0) begin m_st = 1; m_ok = 0; m_bad = 0; end
    hit = near(m, e, t);
    nxt = m_st;
    case (m_st)
      1: if (hit) begin
           m_ok = sat(m_ok + 1); m_bad = 0;
           if (m_ok >= LOCK) nxt = 2;
         end else begin
           m_bad = sat(m_bad + 1); m_ok = 0;
           if (m_bad >= FAIL) nxt = 3;
         end
      2: if (hit) m_bad = 0;
         else begin
           m_bad = sat(m_bad + 1);
           if (m_bad >= FAIL) nxt = 3;
         end
      3: if (hit) begin
           m_ok = sat(m_ok + 1);
           if (m_ok >= LOCK) nxt = 2;
         end else m_ok = 0;
      default: ;
    endcase
    if (nxt != m_st) begin m_ok = 0; m_bad = 0; end
    if (nxt == 3 && m_st != 3) m_stk = 1'b1;
    else if (clr)              m_stk = 1'b0;
    m_st = nxt; m_last = m; m_inr = hit;
    x = '{last: m, inr: hit, st: 2'(nxt), ok: (nxt == 2),
          flt: (nxt == 3), stk: m_stk};
    q.push_back(x);
    repeat (WIN - 1) @(posedge refclk);
    @(negedge refclk);
    clr_sticky = clr;
    @(posedge refclk);
    @(negedge refclk);
    clr_sticky = 1'b0;
    chk("stb_on_window_edge", 32'(sample_stb), 32'd1);
  endtask

  always @(negedge refclk) begin
    if (rst_n === 1'b1 && sample_stb === 1'b1) begin
      if (q.size() == 0) chk("unexpected_stb", 32'd1, 32'd0);
      else begin
        mon_x = q.pop_front();
        chk("last_freq", 32'(last_freq), 32'(mon_x.last));
        chk("in_range", 32'(in_range), 32'(mon_x.inr));
        chk("state", 32'(state), 32'(mon_x.st));
        chk("freq_ok", 32'(freq_ok), 32'(mon_x.ok));
        chk("fault", 32'(fault), 32'(mon_x.flt));
        chk("sticky_fault", 32'(sticky_fault), 32'(mon_x.stk));
      end
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_stb"}, 32'(sample_stb), 32'd0);
    chk({tag, "_last"}, 32'(last_freq), 32'd0);
    chk({tag, "_inr"}, 32'(in_range), 32'd0);
    chk({tag, "_ok"}, 32'(freq_ok), 32'd0);
    chk({tag, "_fault"}, 32'(fault), 32'd0);
    chk({tag, "_sticky"}, 32'(sticky_fault), 32'd0);
  endtask

  initial begin
    logic [28:0] e, t, m;
    int d;
    rst_n = 1'b0; enable = 1'b0; clr_sticky = 1'b0;
    meas_freq = '0; exp_freq = '0; tol_freq = '0;
    model_reset(1'b1);
    repeat (3) @(negedge refclk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge refclk);

    repeat (3) window(29'd1005, 29'd1000, 29'd10, 1'b0);
    chk("lock_state", 32'(state), 32'd2);
    chk("lock_freq_ok", 32'(freq_ok), 32'd1);
    window(29'd1011, 29'd1000, 29'd10, 1'b0);
    window(29'd1011, 29'd1000, 29'd10, 1'b0);
    chk("fault_state", 32'(state), 32'd3);
    window(29'd990, 29'd1000, 29'd10, 1'b0);
    window(29'd995, 29'd1000, 29'd10, 1'b0);
    window(29'd1000, 29'd1000, 29'd10, 1'b0);
    window(29'd1000, 29'd1000, 29'd10, 1'b1);
    window(29'd1011, 29'd1000, 29'd10, 1'b0);
    window(29'd1011, 29'd1000, 29'd10, 1'b1);
    chk("set_beats_clear", 32'(sticky_fault), 32'd1);

    window(29'd1010, 29'd1000, 29'd10, 1'b0);
    window(29'd989, 29'd1000, 29'd10, 1'b0);
    window(29'd990, 29'd1000, 29'd10, 1'b0);
    window(29'h1FFFFFFF, 29'd0, 29'h1FFFFFFF, 1'b0);
    window(29'h1FFFFFFF, 29'd0, 29'h1FFFFFFE, 1'b0);
    window(29'd777, 29'd777, 29'd0, 1'b0);
    window(29'd778, 29'd777, 29'd0, 1'b0);
    repeat (3) window(29'd1000, 29'd1000, 29'd10, 1'b0);
    chk("relock_state", 32'(state), 32'd2);

    repeat (5) @(negedge refclk);
    enable = 1'b0;
    @(negedge refclk);
    model_reset(1'b0);
    chk("dis_state", 32'(state), 32'd0);
    chk("dis_ok", 32'(freq_ok), 32'd0);
    chk("dis_fault", 32'(fault), 32'd0);
    chk("dis_sticky", 32'(sticky_fault), 32'(m_stk));
    chk("dis_last", 32'(last_freq), 32'(m_last));
    chk("dis_inr", 32'(in_range), 32'(m_inr));
    repeat (40) @(negedge refclk);
    chk("dis_no_stb", 32'(sample_stb), 32'd0);
    window(29'd1003, 29'd1000, 29'd10, 1'b0);
    window(29'd1003, 29'd1000, 29'd10, 1'b0);

    repeat (7) @(negedge refclk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    enable = 1'b0;
    model_reset(1'b1);
    @(negedge refclk);
    rst_n = 1'b1;
    @(negedge refclk);

    for (int i = 0; i < 40; i++) begin
      e = 29'($urandom_range(100000, 0));
      t = 29'($urandom_range(50, 0));
      d = int'($urandom_range(2 * int'(t) + 4, 0)) - (int'(t) + 2);
      m = (int'(e) + d < 0) ? 29'd0 : 29'(int'(e) + d);
      window(m, e, t, ($urandom_range(5, 0) == 0));
    end

    repeat (4) @(negedge refclk);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
